// File: rtl/alu_mulseq.sv
// alu_mulseq: 16x16 unsigned MSB-first shift-and-add multiplier that borrows an external ALU.
// Optional: define MULSEQ_SKIPZERO_EN to skip ADD steps for zero multiplier bits.
module alu_mulseq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_c,
    output logic        alu_cin,
    input  logic [15:0] alu_val,
    input  logic        alu_cflag
);
    localparam logic [5:0] ALU_ADD    = 6'b101010;
    localparam logic [5:0] ALU_PASS_X = 6'b100010;

    typedef enum logic [1:0] {IDLE, DBL, ADD, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] prod, mcand, mplier;
    logic [3:0]  cnt;
    logic        bit_set;

    assign bit_set = mplier[cnt];
    assign result  = prod;
    assign alu_cin = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_x     = 16'h0000;
        alu_y     = 16'h0000;
        alu_c     = 6'b000000;
        case (state)
            IDLE: if (start) state_nxt = DBL;
            DBL: begin
                busy  = 1'b1;
                alu_x = prod;
                alu_y = prod;
                alu_c = ALU_ADD;
`ifdef MULSEQ_SKIPZERO_EN
                if (bit_set)         state_nxt = ADD;
                else if (cnt == 4'd0) state_nxt = DONE;
                else                 state_nxt = DBL;
`else
                state_nxt = ADD;
`endif
            end
            ADD: begin
                busy  = 1'b1;
                alu_x = prod;
                alu_y = mcand;
`ifdef MULSEQ_SKIPZERO_EN
                alu_c = ALU_ADD;
`else
                alu_c = bit_set ? ALU_ADD : ALU_PASS_X;
`endif
                state_nxt = (cnt == 4'd0) ? DONE : DBL;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every ALU step folds its carry into ovf; the partial product only grows, so this is exact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod   <= 16'h0000;
            mcand  <= 16'h0000;
            mplier <= 16'h0000;
            cnt    <= 4'd0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= a;
                    mplier <= b;
                    prod   <= 16'h0000;
                    ovf    <= 1'b0;
                    cnt    <= 4'd15;
                end
                DBL: begin
                    prod <= alu_val;
                    ovf  <= ovf | alu_cflag;
`ifdef MULSEQ_SKIPZERO_EN
                    if (!bit_set && cnt != 4'd0) cnt <= cnt - 4'd1;
`endif
                end
                ADD: begin
                    prod <= alu_val;
                    ovf  <= ovf | alu_cflag;
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mulseq.sv
// tb_alu_mulseq: drives alu_mulseq against a behavioural ALU and checks products against a*b.
module tb_alu_mulseq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = 16'h0, b = 16'h0;
    logic        busy, done, ovf, alu_cin, alu_cflag;
    logic [15:0] result, alu_x, alu_y, alu_val;
    logic [5:0]  alu_c;
    logic [15:0] xm, ym;
    logic [16:0] sm;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_mulseq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .ovf(ovf),
        .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_cin(alu_cin),
        .alu_val(alu_val), .alu_cflag(alu_cflag)
    );

    // ALU model: {ex,nx,ey,ny,f,no}; ex/ey enable the operand, f selects add vs and.
    always_comb begin
        xm = alu_c[5] ? alu_x : 16'h0;
        if (alu_c[4]) xm = ~xm;
        ym = alu_c[3] ? alu_y : 16'h0;
        if (alu_c[2]) ym = ~ym;
        sm = alu_c[1] ? ({1'b0, xm} + {1'b0, ym} + {16'h0, alu_cin}) : {1'b0, xm & ym};
        alu_val   = alu_c[0] ? ~sm[15:0] : sm[15:0];
        alu_cflag = sm[16];
    end

    function automatic int exp_lat(input logic [15:0] bv);
`ifdef MULSEQ_SKIPZERO_EN
        return 17 + $countones(bv);
`else
        return 33;
`endif
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input int poke, input string tag);
        logic [31:0] p;
        logic [15:0] exp_res;
        logic        exp_ovf;
        int cyc, dones;
        bit bad_busy, bad_alu, bad_after;
        p = {16'h0, ta} * {16'h0, tbv};
        exp_res = p[15:0];
        exp_ovf = (p[31:16] != 16'h0);
        start = 1'b1; a = ta; b = tbv;
        @(posedge clk); @(negedge clk);
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
        cyc = 1; dones = 0; bad_busy = 0; bad_alu = 0; bad_after = 0;
        while (!done && cyc < 100) begin
            if (busy !== 1'b1 || alu_cin !== 1'b0) bad_busy = 1;
`ifdef MULSEQ_SKIPZERO_EN
            if (alu_c !== 6'b101010) bad_alu = 1;
`else
            if (alu_c !== 6'b101010 && alu_c !== 6'b100010) bad_alu = 1;
`endif
            start = (cyc == poke);
            @(negedge clk); cyc++;
        end
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s timeout: no done after %0d cycles", tag, cyc); end
        checks++; if (cyc != exp_lat(tbv)) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, cyc, exp_lat(tbv)); end
        checks++; if (result !== exp_res) begin errors++; $display("FAIL %s result: got %h expected %h", tag, result, exp_res); end
        checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL %s ovf: got %b expected %b", tag, ovf, exp_ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b expected 0", tag, busy); end
        checks++; if (bad_busy) begin errors++; $display("FAIL %s busy_during_op: got low/cin set expected busy=1 cin=0", tag); end
        checks++; if (bad_alu) begin errors++; $display("FAIL %s alu_c_during_op: got illegal control expected add/pass", tag); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy !== 1'b0 || result !== exp_res || ovf !== exp_ovf) bad_after = 1;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL %s extra_done: got %0d pulses expected 0", tag, dones); end
        checks++; if (bad_after) begin errors++; $display("FAIL %s hold_after_done: got result %h busy %b expected %h idle", tag, result, busy, exp_res); end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, result, ovf, alu_x, alu_y, alu_c, alu_cin} !== 57'h0) begin
            errors++; $display("FAIL reset_state: got busy=%b done=%b result=%h ovf=%b x=%h y=%h c=%b expected all 0",
                              busy, done, result, ovf, alu_x, alu_y, alu_c);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        checks++; if (alu_c !== 6'b000000 || busy !== 1'b0) begin errors++; $display("FAIL idle_outputs: got c=%b busy=%b expected 0", alu_c, busy); end
    endtask

    task automatic test_directed();
        run_op(16'd3, 16'd5, 0, "a3b5");
        run_op(16'hFFFF, 16'hFFFF, 0, "ffff_sq");
        run_op(16'h0100, 16'h0100, 0, "pow_ovf");
        run_op(16'h00FF, 16'h0101, 0, "max_no_ovf");
        run_op(16'h1234, 16'h0000, 0, "b_zero");
        run_op(16'h0000, 16'hBEEF, 0, "a_zero");
    endtask

    task automatic test_ignore_start();
        run_op(16'd7, 16'd9, 10, "ignore_start");
    endtask

    task automatic test_midreset();
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 12; i++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, ovf, alu_x, alu_y, alu_c, alu_cin} !== 57'h0) begin
            errors++; $display("FAIL midreset_outputs: got busy=%b done=%b result=%h ovf=%b x=%h y=%h c=%b expected all 0",
                              busy, done, result, ovf, alu_x, alu_y, alu_c);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_idle: got busy=%b done=%b expected 0", busy, done); end
        run_op(16'd2, 16'd3, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1, b1, a2, b2;
        logic [31:0] p1, p2;
        int cyc;
        a1 = 16'h0123; b1 = 16'h0045; a2 = 16'h0F0F; b2 = 16'h1001;
        p1 = {16'h0, a1} * {16'h0, b1};
        p2 = {16'h0, a2} * {16'h0, b2};
        start = 1'b1; a = a1; b = b1;
        @(posedge clk); @(negedge clk);
        a = a2; b = b2;
        cyc = 1;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        checks++; if (done !== 1'b1 || result !== p1[15:0]) begin errors++; $display("FAIL b2b_first: got done=%b result=%h expected %h", done, result, p1[15:0]); end
        cyc = 0;
        @(negedge clk); cyc++;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        start = 1'b0;
        checks++; if (cyc != 1 + exp_lat(b2)) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", cyc, 1 + exp_lat(b2)); end
        checks++; if (result !== p2[15:0] || ovf !== (p2[31:16] != 16'h0)) begin errors++; $display("FAIL b2b_second: got %h/%b expected %h", result, ovf, p2[15:0]); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: got busy=%b expected 0", busy); end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 3))
                0: begin ra = 16'($urandom); rb = 16'($urandom); end
                1: begin ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255)); end
                2: begin ra = 16'hFFFF - 16'($urandom_range(0, 3)); rb = 16'($urandom_range(1, 2)); end
                default: begin ra = 16'(1) << $urandom_range(0, 15); rb = 16'(1) << $urandom_range(0, 15); end
            endcase
            run_op(ra, rb, 0, "random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_midreset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
